multi_debouncer: RTL and testbench

//  Parametrised N-channel push-button debouncer for the maze board buttons.
//  It synchronises raw pad inputs and samples them on a slow tick (the 100 Hz strobe).
//  Per channel it outputs a clean level plus 1-clk press/release pulses.
//  It also generates an optional auto-repeat pulse train while a button is held.
//  It sits between the board pins and the game FSM, and replaces per-button single-channel debouncers.

---
 rtl/debounce_pkg.sv | 7 +
 rtl/debounce_channel.sv | 95 +++++++++
 rtl/multi_debouncer.sv | 55 +++++
 tb/tb_multi_debouncer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Default constants for the multi-channel button debouncer.
package debounce_pkg;
  localparam int SAMPLE_HZ        = 100;
  localparam int DEF_STABLE_CNT   = 4;
  localparam int DEF_REPEAT_DELAY = 50;
  localparam int DEF_REPEAT_RATE  = 10;
endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability counter, press/release pulses
// and the optional hold-to-repeat pulse train.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CNT   = DEF_STABLE_CNT,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rstN,
  input  logic i_sampleEn,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);
  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level, r_press, r_release;
  logic                   w_syncBtn, w_flip;

  assign w_syncBtn = r_sync[SYNC_STAGES-1];
  // Last disagreeing sample of a full run: level toggles on this edge.
  assign w_flip    = i_sampleEn && (w_syncBtn != r_level) && (r_cnt == CW'(STABLE_CNT - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sync    <= '0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (i_sampleEn) begin
        if ((w_syncBtn == r_level) || w_flip) r_cnt <= '0;
        else                                  r_cnt <= r_cnt + CW'(1);
      end
      if (w_flip) r_level <= ~r_level;
      r_press   <= w_flip & ~r_level;
      r_release <= w_flip & r_level;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

  generate
    if (REPEAT_EN != 0) begin : g_rpt
      localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int HW   = $clog2(HMAX + 1);

      logic [HW-1:0] r_hold;
      logic          r_rptd, r_repeat;
      logic [HW-1:0] w_holdNxt, w_target;

      assign w_holdNxt = (r_hold == HW'(HMAX)) ? r_hold : r_hold + HW'(1);
      // First pulse waits REPEAT_DELAY samples, later ones REPEAT_RATE.
      assign w_target  = r_rptd ? HW'(REPEAT_RATE) : HW'(REPEAT_DELAY);

      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          r_hold   <= '0;
          r_rptd   <= 1'b0;
          r_repeat <= 1'b0;
        end else begin
          r_repeat <= 1'b0;
          if (w_flip) begin
            r_hold <= '0;
            r_rptd <= 1'b0;
          end else if (i_sampleEn && r_level) begin
            if (w_holdNxt == w_target) begin
              r_hold   <= '0;
              r_rptd   <= 1'b1;
              r_repeat <= 1'b1;
            end else begin
              r_hold <= w_holdNxt;
            end
          end
        end
      end

      assign o_repeat = r_repeat;
    end else begin : g_norpt
      assign o_repeat = 1'b0;
    end
  endgenerate
endmodule

// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer: shared sample-tick edge detect feeding
// one debounce_channel per button.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int N_CH         = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_CNT   = DEF_STABLE_CNT,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            tickIn,
  input  logic [N_CH-1:0] rawBtn,
  output logic [N_CH-1:0] btnLevel,
  output logic [N_CH-1:0] btnPress,
  output logic [N_CH-1:0] btnRelease,
  output logic [N_CH-1:0] btnRepeat
);
  logic r_tickPrev, r_sampleEn;

  // Prev resets high so a tick already high at reset release is not a sample.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_tickPrev <= 1'b1;
      r_sampleEn <= 1'b0;
    end else begin
      r_tickPrev <= tickIn;
      r_sampleEn <= tickIn & ~r_tickPrev;
    end
  end

  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT),
        .REPEAT_EN   (REPEAT_EN),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
      ) u_ch (
        .clk       (clk),
        .rstN      (rstN),
        .i_sampleEn(r_sampleEn),
        .i_raw     (rawBtn[g]),
        .o_level   (btnLevel[g]),
        .o_press   (btnPress[g]),
        .o_release (btnRelease[g]),
        .o_repeat  (btnRepeat[g])
      );
    end
  endgenerate
endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed scenarios plus random button traffic,
// checked every clock against a sample-window reference model.
module tb_multi_debouncer;
  localparam int N  = 2;
  localparam int SC = 4;
  localparam int RD = 5;
  localparam int RR = 2;

  logic       clk = 1'b0, rstN = 1'b0, tickIn = 1'b0;
  logic [1:0] rawBtn = 2'b00;
  logic [1:0] btnLevel, btnPress, btnRelease, btnRepeat;
  int         n_tests = 0, n_fail = 0;

  // Model: level flips when the last SC samples all differ from it;
  // repeats fire at DELAY, DELAY+RATE, ... samples after the press.
  logic [1:0] m_lvl;
  logic [7:0] m_hist [N];
  int         m_nv [N];
  int         m_since [N];
  logic [1:0] e_press, e_rel, e_rpt;
  logic [23:0] o_vec, e_vec;

  multi_debouncer #(
    .N_CH(N), .SYNC_STAGES(2), .STABLE_CNT(SC), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rstN(rstN), .tickIn(tickIn), .rawBtn(rawBtn),
    .btnLevel(btnLevel), .btnPress(btnPress), .btnRelease(btnRelease), .btnRepeat(btnRepeat)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_lvl = '0; e_press = '0; e_rel = '0; e_rpt = '0;
    for (int c = 0; c < N; c++) begin
      m_hist[c] = '0; m_nv[c] = 0; m_since[c] = 0;
    end
  endfunction

  function automatic void model_sample(input logic [1:0] s);
    e_press = '0; e_rel = '0; e_rpt = '0;
    for (int c = 0; c < N; c++) begin
      m_hist[c] = {m_hist[c][6:0], s[c]};
      if (m_nv[c] < 8) m_nv[c]++;
      if (m_nv[c] >= SC && m_hist[c][SC-1:0] == {SC{~m_lvl[c]}}) begin
        m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c]) e_press[c] = 1'b1; else e_rel[c] = 1'b1;
        m_since[c] = 0;
      end else if (m_lvl[c]) begin
        m_since[c]++;
        if (m_since[c] >= RD && ((m_since[c] - RD) % RR) == 0) e_rpt[c] = 1'b1;
      end
    end
  endfunction

  // One 100-clk tick period: raw settles, tick rises at k=10, optional glitch
  // k=70..89. Captures pre/at snapshots and any stray pulse or level error.
  task automatic run_period(input logic [1:0] raw, input logic [1:0] gl);
    logic [1:0] old_lvl;
    logic [7:0] pre, at, stray;
    old_lvl = m_lvl;
    model_sample(raw);
    pre = '0; at = '0; stray = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k == 11) pre = {btnLevel, btnPress, btnRelease, btnRepeat};
      if (k == 12) at = {btnLevel, btnPress, btnRelease, btnRepeat};
      else stray[5:0] = stray[5:0] | {btnPress, btnRelease, btnRepeat};
      stray[7:6] = stray[7:6] | (btnLevel ^ ((k >= 12) ? m_lvl : old_lvl));
      if (k == 0)  rawBtn = raw;
      if (k == 10) tickIn = 1'b1;
      if (k == 60) tickIn = 1'b0;
      if (k == 70) rawBtn = raw ^ gl;
      if (k == 90) rawBtn = raw;
    end
    o_vec = {pre, at, stray};
    e_vec = {old_lvl, 6'b0, m_lvl, e_press, e_rel, e_rpt, 8'h00};
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    n_tests++;
    if ({btnLevel, btnPress, btnRelease, btnRepeat} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: got %h exp 00", {btnLevel, btnPress, btnRelease, btnRepeat});
    end
    #29 rstN = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] acc;
    rstN = 1'b0; tickIn = 1'b1; rawBtn = 2'b11; model_reset();
    repeat (5) @(negedge clk);
    n_tests++;
    if ({btnLevel, btnPress, btnRelease, btnRepeat} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_hold: got %h exp 00", {btnLevel, btnPress, btnRelease, btnRepeat});
    end
    rstN = 1'b1; acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc = acc | {btnLevel, btnPress, btnRelease, btnRepeat};
    end
    tickIn = 1'b0;
    n_tests++;
    if (acc !== 8'h00) begin n_fail++; $display("FAIL tick_high_at_release: got %h exp 00", acc); end
    for (int s = 0; s < 4; s++) begin
      run_period(2'b11, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL reset_s%0d: got %h exp %h", s, o_vec, e_vec); end
      n_tests++;
      if (btnLevel !== ((s == 3) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL reset_level_s%0d: got %b", s, btnLevel);
      end
    end
    n_tests++;
    if (o_vec[13:12] !== 2'b11) begin n_fail++; $display("FAIL reset_press: got %b exp 11", o_vec[13:12]); end
  endtask

  task automatic test_release();
    for (int s = 0; s < 6; s++) begin
      run_period(2'b10, (s >= 4) ? 2'b01 : 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL release_s%0d: got %h exp %h", s, o_vec, e_vec); end
      if (s == 3) begin
        n_tests++;
        if (o_vec[11:10] !== 2'b01) begin n_fail++; $display("FAIL release_pulse: got %b exp 01", o_vec[11:10]); end
      end
    end
    n_tests++;
    if (btnLevel !== 2'b10) begin n_fail++; $display("FAIL release_glitch_level: got %b exp 10", btnLevel); end
  endtask

  task automatic test_bounce();
    logic [7:0] seq;
    int presses;
    seq = 8'b1111_0111; presses = 0;
    for (int s = 0; s < 8; s++) begin
      run_period({1'b1, seq[s]}, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL bounce_s%0d: got %h exp %h", s, o_vec, e_vec); end
      presses += int'(o_vec[12]) + int'(o_vec[4]);
      n_tests++;
      if (btnLevel[0] !== (s == 7)) begin n_fail++; $display("FAIL bounce_level_s%0d: got %b", s, btnLevel[0]); end
    end
    n_tests++;
    if (presses != 1) begin n_fail++; $display("FAIL bounce_press_count: got %0d exp 1", presses); end
  endtask

  task automatic test_repeat();
    logic [11:0] mask;
    int late;
    for (int s = 0; s < 8; s++) begin
      run_period((s < 4) ? 2'b00 : 2'b10, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL repeat_setup_s%0d: got %h exp %h", s, o_vec, e_vec); end
    end
    mask = '0;
    for (int s = 0; s < 12; s++) begin
      run_period(2'b10, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL repeat_hold_s%0d: got %h exp %h", s, o_vec, e_vec); end
      mask[s] = o_vec[9];
    end
    n_tests++;
    if (mask !== 12'h550) begin n_fail++; $display("FAIL repeat_mask: got %h exp 550", mask); end
    late = 0;
    for (int s = 0; s < 6; s++) begin
      run_period(2'b00, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL repeat_rel_s%0d: got %h exp %h", s, o_vec, e_vec); end
      if (s >= 3) late += int'(o_vec[9]) + int'(o_vec[1]);
    end
    n_tests++;
    if (late != 0 || btnLevel[1] !== 1'b0) begin
      n_fail++; $display("FAIL repeat_after_release: got %0d pulses level %b exp 0", late, btnLevel[1]);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] seq;
    int rels;
    for (int s = 0; s < 4; s++) begin
      run_period(2'b11, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL simul_s%0d: got %h exp %h", s, o_vec, e_vec); end
    end
    n_tests++;
    if (o_vec[13:12] !== 2'b11) begin n_fail++; $display("FAIL simul_press: got %b exp 11", o_vec[13:12]); end
    seq = 5'b11010; rels = 0;
    for (int s = 0; s < 5; s++) begin
      run_period({1'b1, seq[s]}, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL simul_bounce_s%0d: got %h exp %h", s, o_vec, e_vec); end
      rels += int'(o_vec[11]) + int'(o_vec[10]);
    end
    n_tests++;
    if (btnLevel !== 2'b11 || rels != 0) begin
      n_fail++; $display("FAIL simul_isolation: got level %b releases %0d exp 11 0", btnLevel, rels);
    end
  endtask

  task automatic test_reset_mid();
    for (int s = 0; s < 3; s++) begin
      run_period(2'b00, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL midrst_a_s%0d: got %h exp %h", s, o_vec, e_vec); end
    end
    pulse_reset();
    for (int s = 0; s < 3; s++) run_period(2'b11, 2'b00);
    pulse_reset();
    for (int s = 0; s < 4; s++) begin
      run_period(2'b11, 2'b00);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL midrst_b_s%0d: got %h exp %h", s, o_vec, e_vec); end
      n_tests++;
      if (btnLevel !== ((s == 3) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL midrst_level_s%0d: got %b", s, btnLevel);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] cur, gl;
    cur = 2'b11;
    for (int s = 0; s < 60; s++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 3) == 0) cur[c] = ~cur[c];
      gl = 2'($urandom_range(0, 3));
      run_period(cur, gl);
      n_tests++;
      if (o_vec !== e_vec) begin n_fail++; $display("FAIL random_s%0d: got %h exp %h", s, o_vec, e_vec); end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_bounce();
    test_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
